fruit_scheduler: RTL and testbench
==================================

Name: fruit_scheduler

Overview:
Game-level sequencer for the fruit datapath. Owns NUM_SLOTS fruit slots and decides when each slot spawns (new_fruit pulse) and moves (move_fruit level). Tracks cut count, lives and difficulty level. Drives per-slot fruit instances and the score/HUD logic. One frame_clk cycle equals one video frame.

Parameters:
NUM_SLOTS, 4, number of fruit instances scheduled
MAX_LIVES, 3, lives loaded on game start
SPAWN_BASE, 60, spawn interval in frames at level 0
SPAWN_STEP, 6, interval reduction per level
SPAWN_MIN, 20, floor on spawn interval
CUTS_PER_LEVEL, 5, cuts needed per level increment
MAX_LEVEL, 7, level saturation value
SCORE_W, 8, width of cut counter

Ports:
frame_clk  in  1  frame clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle game start/restart request
fruit_cut  in  NUM_SLOTS  per-slot one-cycle pulse, slice hit detected
fruit_offscreen  in  NUM_SLOTS  per-slot one-cycle pulse, fruit fell below Y max
new_fruit  out  NUM_SLOTS  one-cycle spawn pulse to slot i, registered
move_fruit  out  NUM_SLOTS  slot i advances this frame
slot_active  out  NUM_SLOTS  slot occupancy, registered
score  out  SCORE_W  fruits cut this game, saturating
lives  out  2  remaining lives
level  out  3  difficulty level
fruit_accel  out  4  gravity step for fruit datapath, equals level+1
playing  out  1  high in PLAY
game_over  out  1  high in GAME_OVER

Behaviour:
- One clock, frame_clk; reset asynchronous, active-low (Reset_n). Reset_n low: state IDLE, slot_active=0, new_fruit=0, score=0, lives=0, level=0, spawn counter=0; outputs settle without a clock edge.
- States: IDLE, PLAY, GAME_OVER. IDLE --start--> PLAY. PLAY --lives reach 0--> GAME_OVER. GAME_OVER --start--> PLAY. start in PLAY ignored.
- Entering PLAY: score=0, lives=MAX_LIVES, level=0, slot_active=0, spawn counter loaded SPAWN_BASE-1. First new_fruit pulse is asserted exactly SPAWN_BASE cycles after the start edge.
- Spawn timer in PLAY: decrements each cycle to 0. At 0 with a free slot: pulse new_fruit on the lowest-index free slot, set its slot_active bit, and reload interval-1. interval = max(SPAWN_BASE - level*SPAWN_STEP, SPAWN_MIN). At 0 with no free slot: counter holds at 0, and the spawn fires on the first cycle a slot is free.
- Free-slot selection uses registered slot_active. A slot freed on edge N is spawnable from edge N+1. A freed slot is never respawned on the same edge.
- move_fruit = slot_active when playing, else 0. It is combinational from registers. Slots do not move on their spawn cycle (new_fruit priority inside the slot).
- fruit_cut[i] on an active slot: clear slot_active[i]. score += popcount of valid cuts, saturating at 2^SCORE_W-1. Pulses on inactive slots are ignored.
- fruit_offscreen[i] on an active slot without a cut: clear the slot and subtract from lives. Lives saturate at 0. If cut and offscreen arrive on the same slot in the same cycle, the cut wins (score, no life lost).
- level = min(score / CUTS_PER_LEVEL, MAX_LEVEL), registered. It updates the cycle after score changes. The new interval applies at the next reload.
- The edge that makes lives 0 also enters GAME_OVER. On that edge: slot_active cleared, no new_fruit, score held for display.
- Reset mid-PLAY: immediate return to IDLE; in-flight new_fruit is dropped.

Decomposition:
- Shared package fruit_pkg: game_state_t enum (IDLE, PLAY, GAME_OVER), default constants (SPAWN_BASE, SPAWN_STEP, SPAWN_MIN, MAX_LIVES, CUTS_PER_LEVEL, MAX_LEVEL).
- One sub-module: slot_alloc. It is a combinational lowest-index free-slot priority encoder that outputs a one-hot grant plus an any_free flag.
- Counters and FSM stay in fruit_scheduler.

Test Plan:
- Reset_n low then high, start pulse -> playing=1, lives=3, score=0. new_fruit=4'b0001 exactly 60 cycles after start, then 4'b0010 60 cycles later.
- Slots 0,1 active. Same cycle fruit_cut=4'b0001 and fruit_offscreen=4'b0010 -> score=1, lives=2, slot_active=4'b0000 next edge.
- All 4 slots active, timer expires -> no new_fruit, counter holds 0. fruit_cut=4'b0100 -> new_fruit=4'b0100 on the following edge, not the same edge.
- Drive 5 cuts -> level=1, fruit_accel=2, next interval 54. Drive 40 cuts -> level=7 (capped), interval=max(60-42,20)=20. Drive 300 cuts -> score saturates at 255.
- Three offscreen events with no cuts -> lives 0, game_over=1, slot_active=0, move_fruit=0. start -> PLAY with score=0, lives=3.
- Reset_n asserted mid-PLAY between clock edges -> all outputs reset immediately, state IDLE. start is then required to resume.

Source files
------------

// File: rtl/fruit_pkg.sv
// Shared types and default tuning constants for the fruit game sequencer.
package fruit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  localparam int unsigned MAX_LIVES      = 3;
  localparam int unsigned SPAWN_BASE     = 60;
  localparam int unsigned SPAWN_STEP     = 6;
  localparam int unsigned SPAWN_MIN      = 20;
  localparam int unsigned CUTS_PER_LEVEL = 5;
  localparam int unsigned MAX_LEVEL      = 7;

  // Spawn interval in frames for a given difficulty level.
  function automatic int unsigned spawn_interval(input int unsigned base,
                                                 input int unsigned step,
                                                 input int unsigned min_iv,
                                                 input int unsigned lvl);
    int unsigned red;
    red = lvl * step;
    if (red >= base || (base - red) < min_iv) return min_iv;
    return base - red;
  endfunction

endpackage

// File: rtl/slot_alloc.sv
// Lowest-index free-slot picker: one-hot grant plus an any-free flag.
module slot_alloc #(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] busy_i,
  output logic [NUM_SLOTS-1:0] grant_o,
  output logic                 any_free_o
);

  logic [NUM_SLOTS-1:0] free;

  assign free       = ~busy_i;
  // x & -x isolates the lowest set bit.
  assign grant_o    = free & (~free + NUM_SLOTS'(1));
  assign any_free_o = |free;

endmodule

// File: rtl/fruit_scheduler.sv
// Game-level sequencer: spawn timing, slot occupancy, score, lives and level.
module fruit_scheduler
  import fruit_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_LIVES_P    = MAX_LIVES,
  parameter int SPAWN_BASE_P   = SPAWN_BASE,
  parameter int SPAWN_STEP_P   = SPAWN_STEP,
  parameter int SPAWN_MIN_P    = SPAWN_MIN,
  parameter int CUTS_PER_LVL_P = CUTS_PER_LEVEL,
  parameter int MAX_LEVEL_P    = MAX_LEVEL,
  parameter int SCORE_W        = 8
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] fruit_cut,
  input  logic [NUM_SLOTS-1:0] fruit_offscreen,
  output logic [NUM_SLOTS-1:0] new_fruit,
  output logic [NUM_SLOTS-1:0] move_fruit,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           lives,
  output logic [2:0]           level,
  output logic [3:0]           fruit_accel,
  output logic                 playing,
  output logic                 game_over
);

  localparam int CNT_W = $clog2(SPAWN_BASE_P + 1);
  localparam int CW    = $clog2(NUM_SLOTS + 1);

  game_state_t          state_q, state_d;
  logic [NUM_SLOTS-1:0] slot_active_q, slot_active_d;
  logic [NUM_SLOTS-1:0] new_fruit_q, new_fruit_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic [2:0]           level_q, level_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_SLOTS-1:0] grant, valid_cut, valid_off;
  logic                 any_free;
  logic [CW-1:0]        n_cut, n_off;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat, lvl_raw;
  logic [1:0]           lives_left;
  logic [2:0]           level_calc;
  logic [CNT_W-1:0]     reload_tbl [8];

  // Allocation looks only at registered occupancy, so a slot freed this
  // edge cannot be respawned until the next one.
  slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
    .busy_i    (slot_active_q),
    .grant_o   (grant),
    .any_free_o(any_free)
  );

  for (genvar g = 0; g < 8; g++) begin : g_reload
    assign reload_tbl[g] = CNT_W'(spawn_interval(SPAWN_BASE_P, SPAWN_STEP_P,
                                                 SPAWN_MIN_P, g) - 1);
  end

  assign valid_cut = fruit_cut & slot_active_q;
  assign valid_off = fruit_offscreen & slot_active_q & ~fruit_cut;

  always_comb begin
    n_cut = '0;
    n_off = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n_cut = n_cut + CW'(valid_cut[i]);
      n_off = n_off + CW'(valid_off[i]);
    end
  end

  assign score_sum  = {1'b0, score_q} + (SCORE_W+1)'(n_cut);
  assign score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign lives_left = (n_off >= CW'(lives_q)) ? 2'd0 : lives_q - 2'(n_off);
  assign lvl_raw    = score_q / SCORE_W'(CUTS_PER_LVL_P);
  assign level_calc = (lvl_raw > SCORE_W'(MAX_LEVEL_P)) ? 3'(MAX_LEVEL_P)
                                                         : lvl_raw[2:0];

  always_comb begin
    state_d       = state_q;
    slot_active_d = slot_active_q;
    new_fruit_d   = '0;
    score_d       = score_q;
    lives_d       = lives_q;
    level_d       = level_calc;
    cnt_d         = cnt_q;
    unique case (state_q)
      IDLE, GAME_OVER: begin
        slot_active_d = '0;
        if (start) begin
          state_d = PLAY;
          score_d = '0;
          lives_d = 2'(MAX_LIVES_P);
          level_d = '0;
          cnt_d   = CNT_W'(SPAWN_BASE_P - 1);
        end
      end
      PLAY: begin
        slot_active_d = slot_active_q & ~(valid_cut | valid_off);
        score_d       = score_sat;
        lives_d       = lives_left;
        if (cnt_q == '0) begin
          // Timer parks at zero until a slot is free.
          if (any_free) begin
            new_fruit_d   = grant;
            slot_active_d = slot_active_d | grant;
            cnt_d         = reload_tbl[level_q];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (lives_left == 2'd0) begin
          state_d       = GAME_OVER;
          slot_active_d = '0;
          new_fruit_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      slot_active_q <= '0;
      new_fruit_q   <= '0;
      score_q       <= '0;
      lives_q       <= '0;
      level_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      slot_active_q <= slot_active_d;
      new_fruit_q   <= new_fruit_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
    end
  end

  assign new_fruit   = new_fruit_q;
  assign slot_active = slot_active_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign fruit_accel = {1'b0, level_q} + 4'd1;
  assign playing     = (state_q == PLAY);
  assign game_over   = (state_q == GAME_OVER);
  assign move_fruit  = playing ? slot_active_q : '0;

endmodule

// File: tb/tb_fruit_scheduler.sv
// Scenario tasks plus a randomized run against a frame-level game model.
module tb_fruit_scheduler;

  logic       frame_clk = 1'b0;
  logic       Reset_n   = 1'b1;
  logic       start     = 1'b0;
  logic [3:0] fruit_cut = '0;
  logic [3:0] fruit_offscreen = '0;
  logic [3:0] new_fruit, move_fruit, slot_active;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] level;
  logic [3:0] fruit_accel;
  logic       playing, game_over;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 play, 2 game over
  int         m_state, m_score, m_lives, m_level, m_cnt;
  logic [3:0] m_slots, m_nf;

  fruit_scheduler dut (
    .frame_clk      (frame_clk),
    .Reset_n        (Reset_n),
    .start          (start),
    .fruit_cut      (fruit_cut),
    .fruit_offscreen(fruit_offscreen),
    .new_fruit      (new_fruit),
    .move_fruit     (move_fruit),
    .slot_active    (slot_active),
    .score          (score),
    .lives          (lives),
    .level          (level),
    .fruit_accel    (fruit_accel),
    .playing        (playing),
    .game_over      (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] lowest(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 0; m_level = 0; m_cnt = 0;
    m_slots = '0; m_nf = '0;
  endtask

  task automatic model_step(input logic st, input logic [3:0] cut, input logic [3:0] off);
    int ncut, noff, lvl_next, fr, iv;
    logic [3:0] nxt;
    lvl_next = (m_score / 5 > 7) ? 7 : m_score / 5;
    m_nf = '0;
    if (m_state != 1) begin
      m_slots = '0;
      if (st) begin
        m_state = 1; m_score = 0; m_lives = 3; m_level = 0; m_cnt = 59;
      end else m_level = lvl_next;
    end else begin
      ncut = 0; noff = 0; nxt = m_slots;
      for (int i = 0; i < 4; i++)
        if (m_slots[i]) begin
          if (cut[i]) begin ncut++; nxt[i] = 1'b0; end
          else if (off[i]) begin noff++; nxt[i] = 1'b0; end
        end
      if (m_cnt == 0) begin
        fr = -1;
        for (int i = 3; i >= 0; i--) if (!m_slots[i]) fr = i;
        if (fr >= 0) begin
          m_nf[fr] = 1'b1; nxt[fr] = 1'b1;
          iv = 60 - m_level * 6;
          if (iv < 20) iv = 20;
          m_cnt = iv - 1;
        end
      end else m_cnt--;
      m_score = (m_score + ncut > 255) ? 255 : m_score + ncut;
      m_lives = (m_lives - noff < 0) ? 0 : m_lives - noff;
      m_level = lvl_next;
      m_slots = nxt;
      if (m_lives == 0) begin m_state = 2; m_slots = '0; m_nf = '0; end
    end
  endtask

  task automatic cyc(input logic st, input logic [3:0] cut, input logic [3:0] off);
    start = st; fruit_cut = cut; fruit_offscreen = off;
    @(posedge frame_clk);
    model_step(st, cut, off);
    #1;
    start = 1'b0; fruit_cut = '0; fruit_offscreen = '0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin cyc(1'b0, '0, '0); n++; end while (new_fruit == '0 && n < 300);
  endtask

  task automatic cut_until(input int target, input int bound);
    int k = 0;
    while (m_score < target && k < bound) begin
      cyc(1'b0, lowest(m_slots), '0);
      k++;
    end
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0; model_reset();
    #1;
    checks++;
    if ({new_fruit, slot_active, score, lives, level, playing, game_over, move_fruit} !== '0 ||
        fruit_accel !== 4'd1) begin
      failures++;
      $display("FAIL reset_outputs: nf=%b sa=%b sc=%0d lv=%0d lvl=%0d acc=%0d pl=%b go=%b, want all zero acc=1",
               new_fruit, slot_active, score, lives, level, fruit_accel, playing, game_over);
    end
    #3 Reset_n = 1'b1;
  endtask

  task automatic test_spawn();
    int n;
    cyc(1'b1, '0, '0);
    checks++;
    if (playing !== 1'b1 || lives !== 2'd3 || score !== 8'd0) begin
      failures++;
      $display("FAIL start_state: playing=%b lives=%0d score=%0d, want 1 3 0", playing, lives, score);
    end
    wait_pulse(n);
    checks++;
    if (n !== 60 || new_fruit !== 4'b0001) begin
      failures++;
      $display("FAIL first_spawn: after %0d cycles nf=%b, want 60 cycles nf=0001", n, new_fruit);
    end
    wait_pulse(n);
    checks++;
    if (n !== 60 || new_fruit !== 4'b0010) begin
      failures++;
      $display("FAIL second_spawn: after %0d cycles nf=%b, want 60 cycles nf=0010", n, new_fruit);
    end
  endtask

  task automatic test_cut_offscreen();
    cyc(1'b0, 4'b0001, 4'b0010);
    checks++;
    if (score !== 8'd1 || lives !== 2'd2 || slot_active !== 4'b0000) begin
      failures++;
      $display("FAIL cut_and_off: score=%0d lives=%0d sa=%b, want 1 2 0000", score, lives, slot_active);
    end
    // cut and offscreen on the same slot: cut wins
    while (m_slots == '0) cyc(1'b0, '0, '0);
    cyc(1'b0, 4'b0001, 4'b0001);
    checks++;
    if (score !== 8'd2 || lives !== 2'd2 || slot_active !== 4'b0000) begin
      failures++;
      $display("FAIL cut_wins: score=%0d lives=%0d sa=%b, want 2 2 0000", score, lives, slot_active);
    end
  endtask

  task automatic test_full_slots();
    int k = 0;
    int spurious = 0;
    while (m_slots != 4'hF && k < 400) begin cyc(1'b0, '0, '0); k++; end
    checks++;
    if (slot_active !== 4'hF) begin
      failures++;
      $display("FAIL fill_slots: sa=%b, want 1111", slot_active);
    end
    for (int i = 0; i < 80; i++) begin
      cyc(1'b0, '0, '0);
      if (new_fruit !== 4'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL full_no_spawn: %0d spawn pulses seen, want 0", spurious);
    end
    cyc(1'b0, 4'b0100, '0);
    checks++;
    if (new_fruit !== 4'b0000 || slot_active !== 4'b1011) begin
      failures++;
      $display("FAIL freed_same_edge: nf=%b sa=%b, want 0000 1011", new_fruit, slot_active);
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (new_fruit !== 4'b0100 || slot_active !== 4'b1111) begin
      failures++;
      $display("FAIL freed_next_edge: nf=%b sa=%b, want 0100 1111", new_fruit, slot_active);
    end
  endtask

  task automatic test_level();
    int n;
    int extra = 0;
    int k = 0;
    cut_until(5, 2000);
    checks++;
    if (score !== 8'd5 || level !== 3'd0) begin
      failures++;
      $display("FAIL level_lag: score=%0d level=%0d, want 5 0", score, level);
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (level !== 3'd1 || fruit_accel !== 4'd2) begin
      failures++;
      $display("FAIL level1: level=%0d accel=%0d, want 1 2", level, fruit_accel);
    end
    wait_pulse(n);
    wait_pulse(n);
    checks++;
    if (n !== 54) begin
      failures++;
      $display("FAIL interval_l1: got %0d cycles, want 54", n);
    end
    cut_until(45, 5000);
    cyc(1'b0, '0, '0);
    checks++;
    if (score !== 8'd45 || level !== 3'd7 || fruit_accel !== 4'd8) begin
      failures++;
      $display("FAIL level_cap: score=%0d level=%0d accel=%0d, want 45 7 8", score, level, fruit_accel);
    end
    wait_pulse(n);
    wait_pulse(n);
    checks++;
    if (n !== 20) begin
      failures++;
      $display("FAIL interval_min: got %0d cycles, want 20", n);
    end
    cut_until(255, 12000);
    while (extra < 10 && k < 1000) begin
      if (m_slots != '0) extra++;
      cyc(1'b0, lowest(m_slots), '0);
      k++;
    end
    checks++;
    if (score !== 8'd255 || level !== 3'd7 || lives !== 2'd2) begin
      failures++;
      $display("FAIL score_sat: score=%0d level=%0d lives=%0d, want 255 7 2", score, level, lives);
    end
  endtask

  task automatic test_game_over();
    int k;
    Reset_n = 1'b0; model_reset();
    #2 Reset_n = 1'b1;
    cyc(1'b1, '0, '0);
    k = 0;
    while (m_slots == '0 && k < 100) begin cyc(1'b0, '0, '0); k++; end
    cyc(1'b0, lowest(m_slots), '0);
    for (int e = 0; e < 3; e++) begin
      k = 0;
      while (((e < 2) ? (m_slots == '0) : ($countones(m_slots) < 2)) && k < 300) begin
        cyc(1'b0, '0, '0); k++;
      end
      cyc(1'b0, '0, lowest(m_slots));
    end
    checks++;
    if (game_over !== 1'b1 || playing !== 1'b0 || lives !== 2'd0 || slot_active !== 4'b0 ||
        move_fruit !== 4'b0 || new_fruit !== 4'b0 || score !== 8'd1) begin
      failures++;
      $display("FAIL game_over: go=%b pl=%b lives=%0d sa=%b mv=%b nf=%b score=%0d, want 1 0 0 0000 0000 0000 1",
               game_over, playing, lives, slot_active, move_fruit, new_fruit, score);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'hF, 4'hF);
    cyc(1'b1, '0, '0);
    checks++;
    if (playing !== 1'b1 || game_over !== 1'b0 || score !== 8'd0 || lives !== 2'd3) begin
      failures++;
      $display("FAIL restart: pl=%b go=%b score=%0d lives=%0d, want 1 0 0 3", playing, game_over, score, lives);
    end
  endtask

  task automatic test_reset_mid_play();
    int k = 0;
    while (m_slots == '0 && k < 100) begin cyc(1'b0, '0, '0); k++; end
    #2 Reset_n = 1'b0; model_reset();
    #1;
    checks++;
    if ({new_fruit, slot_active, score, lives, level, playing, game_over, move_fruit} !== '0) begin
      failures++;
      $display("FAIL reset_mid: nf=%b sa=%b score=%0d lives=%0d pl=%b, want all zero",
               new_fruit, slot_active, score, lives, playing);
    end
    #2 Reset_n = 1'b1;
    for (int i = 0; i < 70; i++) cyc(1'b0, '0, '0);
    checks++;
    if (playing !== 1'b0 || new_fruit !== 4'b0 || slot_active !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: pl=%b nf=%b sa=%b, want 0 0000 0000", playing, new_fruit, slot_active);
    end
    cyc(1'b1, '0, '0);
    checks++;
    if (playing !== 1'b1 || lives !== 2'd3) begin
      failures++;
      $display("FAIL resume: pl=%b lives=%0d, want 1 3", playing, lives);
    end
  endtask

  task automatic test_random();
    logic [30:0] act, exp;
    logic [3:0]  c, o;
    logic        s;
    int          shown = 0;
    for (int n = 0; n < 5000; n++) begin
      s = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 4; i++) begin
        c[i] = ($urandom_range(0, 19) == 0);
        o[i] = ($urandom_range(0, 39) == 0);
      end
      cyc(s, c, o);
      act = {new_fruit, slot_active, score, lives, level, fruit_accel, playing, game_over, move_fruit};
      exp = {m_nf, m_slots, 8'(m_score), 2'(m_lives), 3'(m_level), 4'(m_level + 1),
             m_state == 1, m_state == 2, (m_state == 1) ? m_slots : 4'b0};
      checks++;
      if (act !== exp) begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle_%0d: got %h, want %h", n, act, exp);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spawn();
    test_cut_offscreen();
    test_full_slots();
    test_level();
    test_game_over();
    test_reset_mid_play();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
